// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory responder.
//   dmem_state_e      : responder FSM states (CLEAR, IDLE, RESP)
//   DMEM_BASE_DEFAULT : default byte address of word 0 (data segment base)
//   dmem_legal()      : legality test on a base-relative byte offset
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RESP  = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

  // An access is legal when it is word aligned and falls inside the array.
  // The limit is formed in 34 bits so DEPTH*4 cannot overflow the compare.
  function automatic logic dmem_legal(input logic [31:0] off,
                                      input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) << 2;
    return (off[1:0] == 2'b00) && ({2'b00, off} < limit);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// CPU data-port bundle between the CPU top (master) and the responder (slave).
//   ram_ena   : request valid, held until ram_ready=1 is sampled
//   ram_we    : 1 = write, 0 = read
//   ram_addr  : byte address
//   ram_wdata : write data
//   ram_rdata : registered read data
//   ram_ready : current request completes at this edge
//   addr_err  : sticky misaligned / out-of-range flag
// -----------------------------------------------------------------------------
interface dmem_if;

  logic        ram_ena;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic        addr_err;

  modport master (
    output ram_ena,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata,
    input  ram_ready,
    input  addr_err
  );

  modport slave (
    input  ram_ena,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata,
    output ram_ready,
    output addr_err
  );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port DEPTH x 32 word RAM, synchronous write and synchronous read.
// Written so that it maps onto a block RAM (no reset on the storage or on the
// read register).
//   clk     : rising-edge clock
//   i_we    : write enable
//   i_re    : read enable; the read register only updates when set
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data (holds between reads)
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the single-cycle CPU data port. Translates byte
// addresses into word indices, clears the RAM after reset, serves 1-cycle
// writes and 2-cycle reads, and flags illegal accesses in a sticky error bit.
//   ADDR_BASE : byte address of word 0
//   DEPTH     : number of 32-bit words (power of two, >= 2)
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   bus       : dmem_if slave modport (ram_ena/we/addr/wdata in,
//               ram_rdata/ram_ready/addr_err out)
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DMEM_BASE_DEFAULT,
  parameter int          DEPTH     = 1024
) (
  input  logic    clk,
  input  logic    rst,
  dmem_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  dmem_state_e   r_state;
  dmem_state_e   w_state_next;
  logic [AW-1:0] r_clr_cnt;
  logic          r_rd_ok;
  logic          r_addr_err;

  logic [31:0]   w_off;
  logic          w_legal;
  logic [AW-1:0] w_index;
  logic          w_wr_req;
  logic          w_rd_req;
  logic          w_ready;

  logic          w_arr_we;
  logic          w_arr_re;
  logic [AW-1:0] w_arr_addr;
  logic [31:0]   w_arr_wdata;
  logic [31:0]   w_arr_rdata;

  // Address translation. Addresses below the base wrap to huge offsets and
  // fail the range check, so no separate lower-bound compare is needed.
  assign w_off    = bus.ram_addr - ADDR_BASE;
  assign w_legal  = dmem_legal(w_off, DEPTH);
  assign w_index  = w_off[AW+1:2];
  assign w_wr_req = bus.ram_ena &  bus.ram_we;
  assign w_rd_req = bus.ram_ena & ~bus.ram_we;

  // Next-state, handshake and array-port control. ram_ready depends only on
  // the state and ena/we; the address only steers the array enables.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_arr_we     = 1'b0;
    w_arr_re     = 1'b0;
    w_arr_addr   = w_index;
    w_arr_wdata  = bus.ram_wdata;

    case (r_state)
      CLEAR: begin
        // The clear counter owns the array port; requests stay stalled.
        w_arr_we    = 1'b1;
        w_arr_addr  = r_clr_cnt;
        w_arr_wdata = '0;
        if (r_clr_cnt == LAST_WORD) begin
          w_state_next = IDLE;
        end
      end
      IDLE: begin
        w_ready = ~w_rd_req;
        if (w_wr_req) begin
          w_arr_we = w_legal;
        end
        if (w_rd_req) begin
          w_arr_re     = w_legal;
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_ready      = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_cnt  <= '0;
      r_rd_ok    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end

      // r_rd_ok records whether the read in flight was legal. It gates the
      // array output so illegal reads (and the post-reset state) return 0
      // while the RAM read register itself stays reset-free.
      if ((r_state == IDLE) && w_rd_req) begin
        r_rd_ok <= w_legal;
      end

      // The error is raised at the completing edge: the request edge for a
      // write, the RESP edge for a read.
      if ((r_state == IDLE) && w_wr_req && !w_legal) begin
        r_addr_err <= 1'b1;
      end
      if ((r_state == RESP) && !r_rd_ok) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_arr_rdata)
  );

  assign bus.ram_rdata = r_rd_ok ? w_arr_rdata : 32'h0;
  assign bus.ram_ready = w_ready;
  assign bus.addr_err  = r_addr_err;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed self-checking bench for dmem_responder with DEPTH=16.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();

  dmem_responder #(
    .ADDR_BASE (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ena, input logic we,
                       input logic [31:0] addr, input logic [31:0] data);
    bus.ram_ena   = ena;
    bus.ram_we    = we;
    bus.ram_addr  = addr;
    bus.ram_wdata = data;
  endtask

  // Wait out a CLEAR phase and report how many cycles ram_ready stayed low.
  task automatic wait_clear(output int lo);
    lo = 0;
    while (bus.ram_ready !== 1'b1 && lo < 100) begin
      tick();
      lo++;
    end
  endtask

  task automatic test_reset();
    int lo;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    n_checks++; if (bus.ram_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.ram_ready); else n_pass++;
    n_checks++; if (bus.ram_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 00000000", bus.ram_rdata); else n_pass++;
    n_checks++; if (bus.addr_err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.addr_err); else n_pass++;
    tick();
    rst = 1'b0;
    wait_clear(lo);
    n_checks++; if (lo !== 16) $display("FAIL clear_len: got %0d want 16", lo); else n_pass++;
    drive(1'b1, 1'b0, 32'h1001_003C, 32'h0);
    #1;
    n_checks++; if (bus.ram_ready !== 1'b0) $display("FAIL rd15_c1_ready: got %b want 0", bus.ram_ready); else n_pass++;
    tick();
    n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL rd15_c2_ready: got %b want 1", bus.ram_ready); else n_pass++;
    n_checks++; if (bus.ram_rdata !== 32'h0) $display("FAIL rd15_data: got %h want 00000000", bus.ram_rdata); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus.addr_err !== 1'b0) $display("FAIL rd15_err: got %b want 0", bus.addr_err); else n_pass++;
    $display("test_reset: clear=%0d cycles, read 0x1001003C done", lo);
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
    #1;
    n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL wr4_ready: got %b want 1", bus.ram_ready); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    #1;
    n_checks++; if (bus.ram_ready !== 1'b0) $display("FAIL rd4_c1_ready: got %b want 0", bus.ram_ready); else n_pass++;
    tick();
    n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL rd4_c2_ready: got %b want 1", bus.ram_ready); else n_pass++;
    n_checks++; if (bus.ram_rdata !== 32'hDEAD_BEEF) $display("FAIL rd4_data: got %h want deadbeef", bus.ram_rdata); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    $display("test_write_read: wrote/read 0x10010004 = %h", bus.ram_rdata);
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 32'h1001_0002, 32'h1234_5678);
    #1;
    n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL mis_ready: got %b want 1", bus.ram_ready); else n_pass++;
    n_checks++; if (bus.addr_err !== 1'b0) $display("FAIL mis_err_before: got %b want 0", bus.addr_err); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus.addr_err !== 1'b1) $display("FAIL mis_err_after: got %b want 1", bus.addr_err); else n_pass++;
    drive(1'b1, 1'b0, 32'h1001_0000, 32'h0);
    tick();
    n_checks++; if (bus.ram_rdata !== 32'h0) $display("FAIL mis_word0: got %h want 00000000", bus.ram_rdata); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    $display("test_misaligned: write 0x10010002 blocked, err=%b", bus.addr_err);
  endtask

  task automatic test_out_of_range();
    // Seed words 0 and 15, which the illegal addresses alias onto by index.
    drive(1'b1, 1'b1, 32'h1001_0000, 32'hCAFE_0000);
    tick();
    drive(1'b1, 1'b1, 32'h1001_003C, 32'h0F0F_0F0F);
    tick();
    drive(1'b1, 1'b0, 32'h1001_003C, 32'h0);
    tick();
    n_checks++; if (bus.ram_rdata !== 32'h0F0F_0F0F) $display("FAIL oor_seed15: got %h want 0f0f0f0f", bus.ram_rdata); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 32'h1001_0040, 32'h0);
    #1;
    n_checks++; if (bus.ram_ready !== 1'b0) $display("FAIL oor_c1_ready: got %b want 0", bus.ram_ready); else n_pass++;
    tick();
    n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL oor_c2_ready: got %b want 1", bus.ram_ready); else n_pass++;
    n_checks++; if (bus.ram_rdata !== 32'h0) $display("FAIL oor_data: got %h want 00000000", bus.ram_rdata); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 32'h1000_FFFC, 32'h0);
    #1;
    n_checks++; if (bus.ram_ready !== 1'b0) $display("FAIL below_c1_ready: got %b want 0", bus.ram_ready); else n_pass++;
    tick();
    n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL below_c2_ready: got %b want 1", bus.ram_ready); else n_pass++;
    n_checks++; if (bus.ram_rdata !== 32'h0) $display("FAIL below_data: got %h want 00000000", bus.ram_rdata); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (bus.addr_err !== 1'b1) $display("FAIL oor_err_sticky: got %b want 1", bus.addr_err); else n_pass++;
    $display("test_out_of_range: 0x10010040 and 0x1000FFFC read as %h", bus.ram_rdata);
  endtask

  task automatic test_reset_in_resp();
    int lo;
    drive(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    tick();
    n_checks++; if (bus.ram_rdata !== 32'hDEAD_BEEF) $display("FAIL rr_pre_data: got %h want deadbeef", bus.ram_rdata); else n_pass++;
    n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL rr_pre_ready: got %b want 1", bus.ram_ready); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ram_ready !== 1'b0) $display("FAIL rr_async_ready: got %b want 0", bus.ram_ready); else n_pass++;
    n_checks++; if (bus.ram_rdata !== 32'h0) $display("FAIL rr_async_data: got %h want 00000000", bus.ram_rdata); else n_pass++;
    n_checks++; if (bus.addr_err !== 1'b0) $display("FAIL rr_async_err: got %b want 0", bus.addr_err); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    wait_clear(lo);
    n_checks++; if (lo !== 16) $display("FAIL rr_clear_len: got %0d want 16", lo); else n_pass++;
    drive(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    tick();
    n_checks++; if (bus.ram_rdata !== 32'h0) $display("FAIL rr_after_clear: got %h want 00000000", bus.ram_rdata); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    $display("test_reset_in_resp: clear=%0d cycles, word 1 now %h", lo, bus.ram_rdata);
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, BASE + 32'(4 * i), 32'(i + 1));
      #1;
      n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL b2b_wr%0d_ready: got %b want 1", i, bus.ram_ready); else n_pass++;
      tick();
    end
    for (int i = 2; i >= 0; i--) begin
      want = 32'(i + 1);
      drive(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0);
      #1;
      n_checks++; if (bus.ram_ready !== 1'b0) $display("FAIL b2b_rd%0d_c1_ready: got %b want 0", i, bus.ram_ready); else n_pass++;
      tick();
      n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL b2b_rd%0d_c2_ready: got %b want 1", i, bus.ram_ready); else n_pass++;
      n_checks++; if (bus.ram_rdata !== want) $display("FAIL b2b_rd%0d_data: got %h want %h", i, bus.ram_rdata, want); else n_pass++;
      tick();
      $display("test_back_to_back: read word %0d = %h", i, bus.ram_rdata);
    end
    // Idle cycles hold the last read value and keep ready high.
    drive(1'b0, 1'b0, 32'h1001_0008, 32'hFFFF_FFFF);
    tick();
    tick();
    n_checks++; if (bus.ram_rdata !== 32'h1) $display("FAIL idle_hold_data: got %h want 00000001", bus.ram_rdata); else n_pass++;
    n_checks++; if (bus.ram_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", bus.ram_ready); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_reset_in_resp();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
